// File: rtl/rtc_bus_arbiter_pkg.sv
// rtc_bus_arbiter_pkg: arbiter states, RTC register map and requester indices
package rtc_bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  localparam logic [7:0] RTC_SEC = 8'h20, RTC_MIN = 8'h21, RTC_HOUR = 8'h22, RTC_WDAY = 8'h23;
  localparam logic [7:0] RTC_DAY = 8'h24, RTC_MON = 8'h25, RTC_YEAR = 8'h26;
  localparam logic [7:0] RTC_AL_SEC = 8'h31, RTC_AL_MIN = 8'h32, RTC_AL_HOUR = 8'h33, RTC_AL_DAY = 8'h34;
  localparam logic [7:0] RTC_TMR0 = 8'h41, RTC_TMR1 = 8'h42, RTC_TMR2 = 8'h43, RTC_CTRL = 8'h50;
  localparam int REQ_REFRESH = 0, REQ_WRBACK = 1, REQ_INIT = 2;
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rtc_bus_arbiter_if.sv
// rtc_bus_arbiter_if: requester-side and driver-side signals of the RTC bus arbiter
interface rtc_bus_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [NREQ-1:0] req, req_wr, req_lock, gnt, ack;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic err, bus_start, bus_wr, bus_done;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] rdata, bus_wdata, bus_rdata;
  modport master (
    input req, req_wr, req_lock, req_addr, req_wdata, bus_rdata, bus_done,
    output gnt, ack, err, rdata, bus_start, bus_wr, bus_addr, bus_wdata
  );
  modport slave (
    output req, req_wr, req_lock, req_addr, req_wdata, bus_rdata, bus_done,
    input gnt, ack, err, rdata, bus_start, bus_wr, bus_addr, bus_wdata
  );
endinterface

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: one-hot winner of req scanning upward from rr_i with wrap
module rr_priority_pick #(
  parameter int N = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] rr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[(int'(rr_i) + i) % N]) begin
        gnt_o = '0;
        gnt_o[(int'(rr_i) + i) % N] = 1'b1;
        idx_o = IW'((int'(rr_i) + i) % N);
        vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: round-robin owner of the RTC register bus with lock bursts and done timeout
module rtc_bus_arbiter
  import rtc_bus_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int TIMEOUT = 255
) (
  input logic CLK,
  input logic reset,
  rtc_bus_arbiter_if.master bus
);
  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, ack_q, ack_d, win;
  logic [IW-1:0] own_q, own_d, rr_q, rr_d, win_idx, src;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic err_q, err_d, start_q, start_d, wr_q, wr_d, win_vld, relock, lat;
  rr_priority_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req_i(bus.req), .rr_i(rr_q), .gnt_o(win), .idx_o(win_idx), .vld_o(win_vld)
  );
  assign relock = bus.req_lock[own_q] & bus.req[own_q];
  // fields are captured on a fresh grant or on a locked follow-on transfer
  assign lat = (state_q == IDLE && win_vld) || (state_q == DONE && relock);
  assign src = state_q == DONE ? own_q : win_idx;
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    own_d = own_q;
    rr_d = rr_q;
    cnt_d = cnt_q;
    ack_d = '0;
    err_d = 1'b0;
    rdata_d = rdata_q;
    wr_d = lat ? bus.req_wr[src] : wr_q;
    addr_d = lat ? bus.req_addr[AW*src +: AW] : addr_q;
    wdata_d = lat ? bus.req_wdata[DW*src +: DW] : wdata_q;
    case (state_q)
      IDLE: if (win_vld) begin
        state_d = ISSUE;
        gnt_d = win;
        own_d = win_idx;
      end
      ISSUE: begin
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q == CW'(TIMEOUT) ? cnt_q : cnt_q + 1'b1;
        if (bus.bus_done || cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = DONE;
          ack_d = gnt_q;
          err_d = ~bus.bus_done;
          rdata_d = bus.bus_done ? bus.bus_rdata : rdata_q;
        end
      end
      default: if (relock) state_d = ISSUE;
      else begin
        state_d = IDLE;
        gnt_d = '0;
        rr_d = own_q == IW'(NREQ - 1) ? '0 : own_q + 1'b1;
      end
    endcase
  end
  assign start_d = state_d == ISSUE;
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q <= '0;
      ack_q <= '0;
      err_q <= 1'b0;
      start_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q <= '0;
      rr_q <= '0;
      own_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      ack_q <= ack_d;
      err_q <= err_d;
      start_q <= start_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      own_q <= own_d;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.ack = ack_q;
  assign bus.err = err_q;
  assign bus.rdata = rdata_q;
  assign bus.bus_start = start_q;
  assign bus.bus_wr = wr_q;
  assign bus.bus_addr = addr_q;
  assign bus.bus_wdata = wdata_q;
endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb_rtc_bus_arbiter: table, directed and randomized checks against a transaction-level model
module tb_rtc_bus_arbiter;
  localparam int T = 16;
  typedef struct {
    int idx;
    logic wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int d;
    logic [7:0] data;
    logic err;
    logic [7:0] rdata;
  } vec_t;
  logic CLK = 1'b0, reset = 1'b1;
  always #5 CLK = ~CLK;
  rtc_bus_arbiter_if #(.NREQ(3), .AW(8), .DW(8)) bif();
  rtc_bus_arbiter #(.NREQ(3), .AW(8), .DW(8), .TIMEOUT(T)) dut (.CLK(CLK), .reset(reset), .bus(bif));
  int checks = 0, errors = 0, cyc = 0;
  logic [2:0] req_v = 0, wr_v = 0, lock_v = 0, req_drv = 0, last_ack = 0;
  logic [7:0] addr_v[3], wdata_v[3], burst_q[$];
  int burst_left[3];
  bit auto_req = 0, m_idle = 1, m_rel = 0, m_cont = 0, m_err = 0, last_err = 0;
  int m_owner = 0, m_rr = 0, ack_at = -1, done_at = -1, force_d = -1;
  logic [7:0] m_rdata = 0, drv_val = 0, force_data = 0, last_rdata = 0, exp_addr = 0, exp_wdata = 0;
  logic exp_wr = 0;
  int own_log[$];
  logic [7:0] addr_log[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick(logic [2:0] r, int rr);
    for (int k = 0; k < 3; k++) if (r[(rr + k) % 3]) return (rr + k) % 3;
    return -1;
  endfunction

  task automatic drive();
    bif.req = req_v;
    bif.req_wr = wr_v;
    bif.req_lock = lock_v;
    bif.req_addr = {addr_v[2], addr_v[1], addr_v[0]};
    bif.req_wdata = {wdata_v[2], wdata_v[1], wdata_v[0]};
    req_drv = req_v;
  endtask

  task automatic new_req(int i, logic wr, logic [7:0] a, logic [7:0] wd, int bl);
    req_v[i] = 1'b1;
    wr_v[i] = wr;
    addr_v[i] = a;
    wdata_v[i] = wd;
    burst_left[i] = bl;
    lock_v[i] = bl > 0;
  endtask

  // one cycle: model expectations, compare, then requester and driver reactions
  task automatic tick();
    logic [2:0] g_exp, a_exp;
    bit s_exp;
    int d;
    @(negedge CLK);
    cyc++;
    s_exp = m_cont;
    m_cont = 0;
    if (m_idle && req_drv != 0) begin
      m_owner = pick(req_drv, m_rr);
      m_idle = 0;
      s_exp = 1;
    end
    if (m_rel) begin
      m_idle = 1;
      m_rel = 0;
      m_rr = (m_owner + 1) % 3;
    end
    if (s_exp) begin
      exp_addr = addr_v[m_owner];
      exp_wr = wr_v[m_owner];
      exp_wdata = wdata_v[m_owner];
      if (force_d >= 0) d = force_d;
      else if ($urandom_range(0, 9) == 0) d = T;
      else if ($urandom_range(0, 9) == 0) d = T - 1;
      else d = $urandom_range(0, 4);
      drv_val = force_d >= 0 ? force_data : 8'($urandom);
      done_at = d < T ? cyc + 1 + d : -1;
      ack_at = d < T ? cyc + 2 + d : cyc + T + 1;
      m_err = d >= T;
    end
    g_exp = m_idle ? 3'b000 : 3'b001 << m_owner;
    a_exp = cyc == ack_at ? g_exp : 3'b000;
    if (a_exp != 0 && !m_err) m_rdata = drv_val;
    chk("gnt", bif.gnt, g_exp);
    chk("bus_start", bif.bus_start, s_exp);
    chk("ack", bif.ack, a_exp);
    chk("err", bif.err, a_exp != 0 && m_err);
    chk("rdata", bif.rdata, m_rdata);
    if (!m_idle) begin
      chk("bus_addr", bif.bus_addr, exp_addr);
      chk("bus_wr", bif.bus_wr, exp_wr);
      chk("bus_wdata", bif.bus_wdata, exp_wdata);
    end
    if (bif.bus_start) begin
      own_log.push_back(int'(bif.gnt));
      addr_log.push_back(bif.bus_addr);
    end
    last_ack = bif.ack;
    last_err = bif.err;
    last_rdata = bif.rdata;
    for (int i = 0; i < 3; i++) begin
      if (a_exp[i]) begin
        if (burst_left[i] > 0) begin
          burst_left[i]--;
          if (burst_q.size() > 0) addr_v[i] = burst_q.pop_front();
          else addr_v[i] = 8'($urandom);
          wdata_v[i] = 8'($urandom);
          m_cont = 1;
        end else begin
          req_v[i] = 1'b0;
          m_rel = 1;
        end
      end else if (auto_req && !req_v[i] && $urandom_range(0, 3) == 0)
        new_req(i, 1'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(0, 4) == 0 ? int'($urandom_range(1, 3)) : 0);
    end
    bif.bus_done = cyc == done_at || (auto_req && m_idle && $urandom_range(0, 7) == 0);
    bif.bus_rdata = cyc == done_at ? drv_val : 8'($urandom);
    drive();
  endtask

  task automatic run_row(vec_t v);
    int n = 0;
    force_d = v.d;
    force_data = v.data;
    new_req(v.idx, v.wr, v.addr, v.wdata, 0);
    drive();
    do begin
      tick();
      n++;
    end while (!last_ack[v.idx] && n < 100);
    chk("row_ack", last_ack[v.idx], 1);
    chk("row_err", last_err, v.err);
    chk("row_rdata", last_rdata, v.rdata);
    tick();
    tick();
  endtask

  initial begin
    vec_t tbl[6];
    logic [7:0] lst[13];
    int n;
    tbl = '{'{1, 1'b0, 8'h21, 8'h00, 4, 8'h59, 1'b0, 8'h59},
            '{0, 1'b1, 8'h50, 8'h80, 0, 8'h3C, 1'b0, 8'h3C},
            '{2, 1'b0, 8'h41, 8'h00, T, 8'hEE, 1'b1, 8'h3C},
            '{2, 1'b0, 8'h42, 8'h00, T - 1, 8'hA7, 1'b0, 8'hA7},
            '{0, 1'b0, 8'h31, 8'h00, 2, 8'h12, 1'b0, 8'h12},
            '{1, 1'b1, 8'h26, 8'h55, T + 3, 8'h99, 1'b1, 8'h12}};
    lst = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42};
    for (int i = 0; i < 3; i++) begin
      addr_v[i] = 0;
      wdata_v[i] = 0;
      burst_left[i] = 0;
    end
    bif.bus_done = 1'b0;
    bif.bus_rdata = 8'h00;
    drive();
    tick();
    tick();
    chk("rst_bus_wr", bif.bus_wr, 0);
    chk("rst_bus_addr", bif.bus_addr, 0);
    chk("rst_bus_wdata", bif.bus_wdata, 0);
    reset = 1'b0;
    for (int r = 0; r < 6; r++) run_row(tbl[r]);
    // async reset while the transfer waits on the driver
    force_d = T;
    new_req(0, 1'b1, 8'h33, 8'h77, 0);
    drive();
    n = 0;
    do begin
      tick();
      n++;
    end while (!bif.bus_start && n < 20);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_gnt", bif.gnt, 0);
    chk("arst_ack", bif.ack, 0);
    chk("arst_err", bif.err, 0);
    chk("arst_start", bif.bus_start, 0);
    chk("arst_wr", bif.bus_wr, 0);
    chk("arst_addr", bif.bus_addr, 0);
    chk("arst_wdata", bif.bus_wdata, 0);
    chk("arst_rdata", bif.rdata, 0);
    req_v = 0;
    lock_v = 0;
    for (int i = 0; i < 3; i++) burst_left[i] = 0;
    m_idle = 1;
    m_rel = 0;
    m_cont = 0;
    m_rr = 0;
    m_rdata = 0;
    ack_at = -1;
    done_at = -1;
    bif.bus_done = 1'b0;
    drive();
    tick();
    tick();
    reset = 1'b0;
    tick();
    run_row('{2, 1'b0, 8'h24, 8'h00, 1, 8'h6B, 1'b0, 8'h6B});
    // contention: all three at once from pointer 0
    own_log.delete();
    force_d = 1;
    force_data = 8'h00;
    for (int i = 0; i < 3; i++) new_req(i, 1'b1, 8'h20 + 8'(i), 8'h40 + 8'(i), 0);
    drive();
    n = 0;
    do begin
      tick();
      n++;
    end while (req_v != 0 && n < 100);
    chk("cont_n", own_log.size(), 3);
    for (int k = 0; k < 3; k++) chk("cont_order", own_log[k], 1 << k);
    tick();
    tick();
    // locked 13-register write-back while requester 0 waits
    own_log.delete();
    addr_log.delete();
    force_d = 2;
    for (int k = 1; k < 13; k++) burst_q.push_back(lst[k]);
    new_req(1, 1'b1, lst[0], 8'h11, 12);
    drive();
    n = 0;
    do begin
      tick();
      n++;
    end while (!bif.gnt[1] && n < 20);
    new_req(0, 1'b0, 8'h50, 8'h00, 0);
    drive();
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_ack[0] && n < 400);
    chk("burst_n", addr_log.size(), 14);
    for (int k = 0; k < 13; k++) begin
      chk("burst_own", own_log[k], 2);
      chk("burst_addr", addr_log[k], lst[k]);
    end
    chk("burst_tail", own_log[13], 1);
    tick();
    tick();
    auto_req = 1;
    force_d = -1;
    repeat (2000) tick();
    auto_req = 0;
    n = 0;
    while ((req_v != 0 || !m_idle) && n < 500) begin
      tick();
      n++;
    end
    chk("drain", req_v, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
